// File: rtl/mc_bus_responder.sv
// rtl/mc_bus_responder.sv - MCU async parallel bus responder bridging to BPSM FIFOs and registers
module mc_bus_responder #(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mc_ce,
    input  logic                     mc_we,
    input  logic                     mc_oe,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    inout  wire  [MC_DATA_WIDTH-1:0] mc_data,
    output logic [MC_DATA_WIDTH-1:0] fifo_in_data,
    output logic                     fifo_in_cmd,
    output logic                     fifo_in_push,
    input  logic                     fifo_in_full,
    input  logic [MC_DATA_WIDTH-1:0] fifo_out_data,
    output logic                     fifo_out_pop,
    input  logic                     fifo_out_empty,
    output logic [MC_ADD_WIDTH-1:0]  reg_add,
    output logic [MC_DATA_WIDTH-1:0] reg_wdata,
    output logic                     reg_we,
    output logic                     reg_re,
    input  logic [MC_DATA_WIDTH-1:0] reg_rdata,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     conflict,
    input  logic                     flag_clear
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        RD_FETCH,
        RD_HOLD
    } state_t;

    state_t state, state_nxt;

    // Chains reset to the asserted level so a strobe held low across reset never forms an edge.
    logic [SYNC_STAGES-1:0] ce_sync, we_sync, oe_sync;
    logic ce_s, we_s, oe_s;
    logic we_prev, oe_prev;
    logic we_fall, oe_fall, conflict_evt;

    logic acc_fifo;
    logic rd_zero;
    logic [MC_DATA_WIDTH-1:0] rd_word;

    logic push_nxt, reg_we_nxt, pop_nxt, reg_re_nxt;
    logic ovf_set, unf_set, cfl_set;
    logic wr_start, rd_start, capture;

    assign ce_s = ce_sync[SYNC_STAGES-1];
    assign we_s = we_sync[SYNC_STAGES-1];
    assign oe_s = oe_sync[SYNC_STAGES-1];

    assign we_fall = we_prev & ~we_s;
    assign oe_fall = oe_prev & ~oe_s;
    assign conflict_evt = ~ce_s & ((we_fall & ~oe_s) | (oe_fall & ~we_s));

    assign mc_data = (state == RD_HOLD && !mc_oe && !mc_ce) ? rd_word : {MC_DATA_WIDTH{1'bz}};

    always_comb begin
        state_nxt  = state;
        push_nxt   = 1'b0;
        reg_we_nxt = 1'b0;
        pop_nxt    = 1'b0;
        reg_re_nxt = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        cfl_set    = 1'b0;
        wr_start   = 1'b0;
        rd_start   = 1'b0;
        capture    = 1'b0;
        if (conflict_evt) begin
            cfl_set   = 1'b1;
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!ce_s && we_fall) begin
                        wr_start  = 1'b1;
                        state_nxt = WR_ISSUE;
                    end else if (!ce_s && oe_fall) begin
                        rd_start  = 1'b1;
                        state_nxt = RD_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (acc_fifo) begin
                        ovf_set  = fifo_in_full;
                        push_nxt = ~fifo_in_full;
                    end else begin
                        reg_we_nxt = 1'b1;
                    end
                    state_nxt = WR_WAIT;
                end
                WR_WAIT: begin
                    if (we_s || ce_s) state_nxt = IDLE;
                end
                RD_ISSUE: begin
                    if (acc_fifo) begin
                        unf_set = fifo_out_empty;
                        pop_nxt = ~fifo_out_empty;
                    end else begin
                        reg_re_nxt = 1'b1;
                    end
                    state_nxt = RD_WAIT;
                end
                RD_WAIT:  state_nxt = RD_FETCH;
                RD_FETCH: begin
                    capture   = 1'b1;
                    state_nxt = RD_HOLD;
                end
                RD_HOLD: begin
                    if (oe_s || ce_s) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ce_sync      <= '0;
            we_sync      <= '0;
            oe_sync      <= '0;
            we_prev      <= 1'b0;
            oe_prev      <= 1'b0;
            state        <= IDLE;
            fifo_in_push <= 1'b0;
            reg_we       <= 1'b0;
            fifo_out_pop <= 1'b0;
            reg_re       <= 1'b0;
            fifo_in_data <= '0;
            fifo_in_cmd  <= 1'b0;
            reg_add      <= '0;
            reg_wdata    <= '0;
            rd_word      <= '0;
            rd_zero      <= 1'b0;
            acc_fifo     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            conflict     <= 1'b0;
        end else begin
            ce_sync      <= {ce_sync[SYNC_STAGES-2:0], mc_ce};
            we_sync      <= {we_sync[SYNC_STAGES-2:0], mc_we};
            oe_sync      <= {oe_sync[SYNC_STAGES-2:0], mc_oe};
            we_prev      <= we_s;
            oe_prev      <= oe_s;
            state        <= state_nxt;
            fifo_in_push <= push_nxt;
            reg_we       <= reg_we_nxt;
            fifo_out_pop <= pop_nxt;
            reg_re       <= reg_re_nxt;
            if (wr_start) begin
                acc_fifo <= (mc_add[MC_ADD_WIDTH-1:1] == '0);
                if (mc_add[MC_ADD_WIDTH-1:1] == '0) begin
                    fifo_in_data <= mc_data;
                    fifo_in_cmd  <= mc_add[0];
                end else begin
                    reg_add   <= mc_add;
                    reg_wdata <= mc_data;
                end
            end
            if (rd_start) begin
                acc_fifo <= (mc_add == '0);
                rd_zero  <= 1'b0;
                if (mc_add != '0) reg_add <= mc_add;
            end
            // An empty-FIFO read still completes, but returns zero instead of a stale head.
            if (unf_set) rd_zero <= 1'b1;
            if (capture) begin
                if (rd_zero)       rd_word <= '0;
                else if (acc_fifo) rd_word <= fifo_out_data;
                else               rd_word <= reg_rdata;
            end
            overflow  <= ovf_set | (overflow  & ~flag_clear);
            underflow <= unf_set | (underflow & ~flag_clear);
            conflict  <= cfl_set | (conflict  & ~flag_clear);
        end
    end

endmodule

// File: tb/tb_mc_bus_responder.sv
// tb/tb_mc_bus_responder.sv - directed self-checking bench for mc_bus_responder
module tb_mc_bus_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        mc_ce, mc_we, mc_oe;
    logic [5:0]  mc_add;
    wire  [15:0] mc_data;
    logic [15:0] tb_data;
    logic        tb_drive;
    logic [15:0] fifo_in_data;
    logic        fifo_in_cmd, fifo_in_push, fifo_in_full;
    logic [15:0] fifo_out_data;
    logic        fifo_out_pop, fifo_out_empty;
    logic [5:0]  reg_add;
    logic [15:0] reg_wdata, reg_rdata;
    logic        reg_we, reg_re;
    logic        overflow, underflow, conflict, flag_clear;

    logic [15:0] regs [64];
    logic [15:0] fifo_head;

    int checks = 0;
    int errors = 0;
    int n_push = 0, n_we = 0, n_pop = 0, n_re = 0;
    logic [15:0] last_push_data, last_reg_wdata;
    logic        last_push_cmd;
    logic [5:0]  last_reg_add;

    always #5 clock = ~clock;

    assign mc_data = tb_drive ? tb_data : 16'hzzzz;

    // Undriven bus reads back as all ones so a released bus is observable.
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (mc_data[i]);
    end

    mc_bus_responder #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset),
        .mc_ce(mc_ce), .mc_we(mc_we), .mc_oe(mc_oe),
        .mc_add(mc_add), .mc_data(mc_data),
        .fifo_in_data(fifo_in_data), .fifo_in_cmd(fifo_in_cmd),
        .fifo_in_push(fifo_in_push), .fifo_in_full(fifo_in_full),
        .fifo_out_data(fifo_out_data), .fifo_out_pop(fifo_out_pop),
        .fifo_out_empty(fifo_out_empty),
        .reg_add(reg_add), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata),
        .overflow(overflow), .underflow(underflow), .conflict(conflict),
        .flag_clear(flag_clear)
    );

    always @(posedge clock) begin
        if (reg_we) regs[reg_add] <= reg_wdata;
        if (reg_re) reg_rdata <= regs[reg_add];
        if (fifo_out_pop) fifo_out_data <= fifo_head;
    end

    always @(negedge clock) begin
        if (fifo_in_push) begin
            n_push++;
            last_push_data = fifo_in_data;
            last_push_cmd  = fifo_in_cmd;
        end
        if (reg_we) begin
            n_we++;
            last_reg_add   = reg_add;
            last_reg_wdata = reg_wdata;
        end
        if (fifo_out_pop) n_pop++;
        if (reg_re) n_re++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_write(input logic [5:0] a, input logic [15:0] d, input int len);
        mc_add = a; tb_data = d; tb_drive = 1'b1; mc_ce = 1'b0;
        tick(3);
        mc_we = 1'b0;
        tick(len);
        mc_we = 1'b1; mc_ce = 1'b1;
        tick(1);
        tb_drive = 1'b0;
        tick(4);
    endtask

    task automatic do_read(input logic [5:0] a, output logic [15:0] d);
        mc_add = a; mc_ce = 1'b0;
        tick(3);
        mc_oe = 1'b0;
        tick(7);
        d = mc_data;
        mc_oe = 1'b1; mc_ce = 1'b1;
        tick(5);
    endtask

    initial begin
        int b_push, b_we, b_pop, b_re;
        logic [15:0] rd;

        reset = 1'b1; mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1; mc_add = '0;
        tb_data = '0; tb_drive = 1'b0; fifo_in_full = 1'b0; fifo_out_empty = 1'b0;
        fifo_out_data = '0; reg_rdata = '0; flag_clear = 1'b0; fifo_head = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_push", fifo_in_push, 0);
        check("rst_flags", {overflow, underflow, conflict}, 0);
        check("rst_regs", {fifo_in_data, fifo_in_cmd, reg_add, reg_wdata}, 0);
        check("rst_bus_z", mc_data, 16'hFFFF);
        tick(4);

        // Command push with exact pulse timing
        b_push = n_push; b_we = n_we;
        mc_add = 6'h01; tb_data = 16'h0012; tb_drive = 1'b1; mc_ce = 1'b0;
        tick(3);
        mc_we = 1'b0;
        tick(3);
        check("push_early", fifo_in_push, 0);
        tick(1);
        check("push_on", fifo_in_push, 1);
        check("push_cmd", fifo_in_cmd, 1);
        check("push_data", fifo_in_data, 16'h0012);
        tick(1);
        check("push_one_cycle", fifo_in_push, 0);
        tick(1);
        mc_we = 1'b1; mc_ce = 1'b1;
        tick(1);
        tb_drive = 1'b0;
        tick(4);
        check("push_count", n_push - b_push, 1);
        check("push_no_we", n_we - b_we, 0);

        // Register write then read-back with bus timing
        b_we = n_we; b_re = n_re; b_push = n_push;
        do_write(6'h03, 16'h00FF, 6);
        check("regw_count", n_we - b_we, 1);
        check("regw_add", last_reg_add, 6'h03);
        check("regw_data", last_reg_wdata, 16'h00FF);
        check("regw_no_push", n_push - b_push, 0);
        mc_add = 6'h03; mc_ce = 1'b0;
        tick(3);
        mc_oe = 1'b0;
        tick(5);
        check("rd_not_yet", mc_data, 16'hFFFF);
        tick(1);
        check("rd_driven", mc_data, 16'h00FF);
        tick(2);
        mc_oe = 1'b1;
        #1;
        check("rd_release", mc_data, 16'hFFFF);
        mc_ce = 1'b1;
        tick(5);
        check("rd_re_count", n_re - b_re, 1);

        // FIFO reads: normal and empty
        b_pop = n_pop;
        fifo_head = 16'hA55A;
        do_read(6'h00, rd);
        check("pop_data", rd, 16'hA55A);
        check("pop_count", n_pop - b_pop, 1);
        check("pop_no_unf", underflow, 0);
        b_pop = n_pop;
        fifo_head = 16'h1234; fifo_out_empty = 1'b1;
        do_read(6'h00, rd);
        check("empty_data", rd, 16'h0000);
        check("empty_no_pop", n_pop - b_pop, 0);
        tick(3);
        check("unf_sticky", underflow, 1);
        flag_clear = 1'b1; tick(1); flag_clear = 1'b0; tick(1);
        check("unf_cleared", underflow, 0);
        fifo_out_empty = 1'b0;

        // Full input FIFO
        b_push = n_push; b_we = n_we;
        fifo_in_full = 1'b1;
        do_write(6'h00, 16'h0055, 5);
        check("full_no_push", n_push - b_push, 0);
        check("ovf_set", overflow, 1);
        do_write(6'h05, 16'h0077, 5);
        check("full_regw", n_we - b_we, 1);
        check("full_regw_add", last_reg_add, 6'h05);
        check("ovf_sticky", overflow, 1);
        fifo_in_full = 1'b0;
        flag_clear = 1'b1; tick(1); flag_clear = 1'b0; tick(1);
        check("ovf_cleared", overflow, 0);

        // we and oe together
        b_push = n_push; b_we = n_we; b_pop = n_pop; b_re = n_re;
        mc_add = 6'h07; mc_ce = 1'b0;
        tick(3);
        mc_we = 1'b0; mc_oe = 1'b0;
        tick(8);
        check("cfl_bus_z", mc_data, 16'hFFFF);
        check("cfl_set", conflict, 1);
        mc_we = 1'b1; mc_oe = 1'b1; mc_ce = 1'b1;
        tick(5);
        check("cfl_no_pulse", (n_push - b_push) + (n_we - b_we) + (n_pop - b_pop) + (n_re - b_re), 0);

        // Write with ce high
        b_we = n_we;
        mc_add = 6'h09; tb_data = 16'h0BAD; tb_drive = 1'b1;
        tick(3);
        mc_we = 1'b0;
        tick(6);
        mc_we = 1'b1;
        tick(1);
        tb_drive = 1'b0;
        tick(4);
        check("ce_high_no_we", n_we - b_we, 0);

        // Strobe held low across reset
        b_we = n_we;
        mc_add = 6'h04; tb_data = 16'h0099; tb_drive = 1'b1; mc_ce = 1'b0;
        tick(3);
        mc_we = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);
        check("rst_hold_no_we", n_we - b_we, 0);
        check("rst_clears_cfl", conflict, 0);
        mc_we = 1'b1;
        tick(4);
        mc_we = 1'b0;
        tick(6);
        mc_we = 1'b1; mc_ce = 1'b1;
        tick(1);
        tb_drive = 1'b0;
        tick(4);
        check("rst_after_we", n_we - b_we, 1);
        check("rst_after_data", last_reg_wdata, 16'h0099);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_bus_responder.md
# mc_bus_responder

FPGA-side responder for the MCU asynchronous parallel bus (mc_ce/mc_we/mc_oe, 6-bit address, 16-bit data). It synchronizes the active-low strobes into the `clock` domain and turns each MCU write into one push or register-write pulse. It turns each MCU read into one FIFO-pop or register-read pulse, then drives the fetched word onto mc_data. It sits between the top-level mc_* pins and the BPSM input/output FIFOs and register file.

## Interface
- MC_DATA_WIDTH, 16, data bus width
- MC_ADD_WIDTH, 6, address bus width
- SYNC_STAGES, 2, flops per strobe synchronizer (≥2)

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- mc_ce  in  1  chip enable, active low, asynchronous
- mc_we  in  1  write strobe, active low, asynchronous
- mc_oe  in  1  output enable, active low, asynchronous
- mc_add  in  MC_ADD_WIDTH  address
- mc_data  inout  MC_DATA_WIDTH  data bus
- fifo_in_data  out  MC_DATA_WIDTH  word for BPSM input FIFO
- fifo_in_cmd  out  1  1 = command word (addr 0x01), 0 = data word (addr 0x00)
- fifo_in_push  out  1  one-cycle push
- fifo_in_full  in  1  input FIFO full
- fifo_out_data  in  MC_DATA_WIDTH  output FIFO head, valid 1 cycle after pop
- fifo_out_pop  out  1  one-cycle pop
- fifo_out_empty  in  1  output FIFO empty
- reg_add  out  MC_ADD_WIDTH  register address
- reg_wdata  out  MC_DATA_WIDTH  register write data
- reg_we  out  1  one-cycle register write
- reg_re  out  1  one-cycle register read
- reg_rdata  in  MC_DATA_WIDTH  register data, valid 1 cycle after reg_re
- overflow  out  1  sticky: write to 0x00/0x01 while fifo_in_full
- underflow  out  1  sticky: read of 0x00 while fifo_out_empty
- conflict  out  1  sticky: we and oe both asserted
- flag_clear  in  1  clears all three sticky flags

## Operation
- Each of ce/we/oe passes through a SYNC_STAGES flop chain. Chains reset to 0 (asserted), so a strobe held low through reset is ignored until it has been seen high.
- An event is a synchronized high→low edge of we or oe while synchronized ce is low.
- States:
  - IDLE
  - WR_WAIT
  - RD_FETCH
  - RD_HOLD
- IDLE, we edge (oe high): latch mc_add/mc_data, issue the write pulse next cycle, go to WR_WAIT.
  - Address 0x00 or 0x01: fifo_in_push, with fifo_in_cmd = add[0]. If fifo_in_full: no push, set overflow.
  - Any other address: reg_we with reg_add/reg_wdata.
- WR_WAIT: return to IDLE when synchronized we or ce goes high. No further pulses.
- IDLE, oe edge (we high): latch mc_add, issue the read pulse, go to RD_FETCH.
  - Address 0x00: fifo_out_pop. If fifo_out_empty: no pop, read word forced to 0x0000, set underflow.
  - Any other address: reg_re.
- RD_FETCH, one cycle: capture fifo_out_data or reg_rdata into rd_word, go to RD_HOLD.
- RD_HOLD: return to IDLE when synchronized oe or ce goes high.
- mc_data driver enable = (state==RD_HOLD) & ~mc_oe & ~mc_ce, using the raw pins combinationally. Driven value is rd_word; otherwise hi-z. Release is immediate when the MCU raises oe.
- Edge on we and oe in the same cycle, or one asserted while the other is already low: set conflict, issue no pulse, stay in or return to IDLE.
- flag_clear and a flag-setting event in the same cycle: set wins.

## Timing
- Reset values:
  - all pulses 0
  - mc_data hi-z
  - overflow/underflow/conflict 0
  - fifo_in_data, fifo_in_cmd, reg_add, reg_wdata, rd_word all 0
  - state IDLE
- Reset mid-transaction aborts it with no pulse.
- Strobe falls before posedge t: edge is detected at posedge t+SYNC_STAGES. The push/reg_we/pop/reg_re pulse is high for exactly the one cycle after posedge t+SYNC_STAGES+1.
- mc_add/mc_data must be stable from SYNC_STAGES+1 cycles before the strobe falls until the strobe rises.
- Read: rd_word valid and driven from posedge t+SYNC_STAGES+3.
  - The MCU must hold oe low ≥ SYNC_STAGES+4 cycles.
  - Minimum strobe low time is 4 cycles; minimum high time between accesses is SYNC_STAGES+1 cycles.
- Exactly one pulse per strobe assertion, regardless of its length.

## Test plan
- we low 6 cycles at add 0x01, data 0x0012 (ce low) → exactly one fifo_in_push, fifo_in_cmd=1, fifo_in_data=0x0012, 3 cycles after we fell.
- Write 0x00FF to add 0x03, then read add 0x03 with reg_rdata model returning 0x00FF → one reg_we (add 0x03, 0x00FF); one reg_re; mc_data=0x00FF from cycle 5 after oe fell; hi-z same cycle oe rises.
- Read add 0x00 with fifo_out_empty=0, head 0xA55A → one fifo_out_pop, mc_data=0xA55A. Repeat with fifo_out_empty=1 → no pop, mc_data=0x0000, underflow=1 until flag_clear.
- Write add 0x00 with fifo_in_full=1 → no push, overflow=1. Writes to other addresses still produce reg_we.
- we and oe driven low together → no pulses, conflict=1, mc_data stays hi-z. Then ce high during a write → no pulse.
- Hold we low, pulse reset, keep we low 10 more cycles → no pulse. Release we, assert again → one pulse.
